// File: rtl/mcd_bus_ctrl.sv
// mcd_bus_ctrl: 68000-side bus controller for the MCD212-class chip.
// Decodes RAM/ROM/sys-I/O/channel windows, applies the boot ROM overlay,
// runs RAM cycles over req/ack and returns a one-cycle bus_ack.
// Ports:
//   clk, reset_n            clock, async active-low reset
//   address, din, dout      CPU word address [22:1], write data, read data
//   uds, lds, write_strobe  byte strobes, 1 = write
//   cs, bus_ack, csrom      cycle select, transfer done, ROM select
//   ram_*                   request/ack interface to the memory controller
//   display_active, parity  per-channel status inputs (clk domain)
//   ch_regs                 flattened channel register file
module mcd_bus_ctrl #(
    parameter int RAM_AW        = 21,
    parameter int BOOT_ACCESSES = 4,
    parameter int NUM_CH        = 2,
    parameter int REGS_PER_CH   = 8
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [22:1]                     address,
    input  logic [15:0]                     din,
    output logic [15:0]                     dout,
    input  logic                            uds,
    input  logic                            lds,
    input  logic                            write_strobe,
    input  logic                            cs,
    output logic                            bus_ack,
    output logic                            csrom,
    output logic                            ram_req,
    output logic                            ram_we,
    output logic [1:0]                      ram_be,
    output logic [RAM_AW-1:0]               ram_addr,
    output logic [15:0]                     ram_wdata,
    input  logic [15:0]                     ram_rdata,
    input  logic                            ram_ack,
    input  logic [NUM_CH-1:0]               display_active,
    input  logic [NUM_CH-1:0]               parity,
    output logic [NUM_CH*REGS_PER_CH*16-1:0] ch_regs
);

    // +2 keeps the counter at least one bit wide for any overlay length
    localparam int BCW = $clog2(BOOT_ACCESSES + 2);
    localparam logic [BCW-1:0] BOOT_MAX = BCW'(BOOT_ACCESSES);

    typedef enum logic [1:0] {
        IDLE,
        RAM_WAIT,
        ACK,
        RELEASE
    } state_t;

    state_t           r_state;
    logic [BCW-1:0]   r_boot_cnt;
    logic             r_cs_d;
    logic             r_abort;
    logic [15:0]      r_dout;
    logic             r_bus_ack;
    logic             r_ram_req;
    logic             r_ram_we;
    logic [1:0]       r_ram_be;
    logic [RAM_AW-1:0] r_ram_addr;
    logic [15:0]      r_ram_wdata;
    logic [15:0]      r_regs [NUM_CH][REGS_PER_CH];

    logic       w_in_top;
    logic [7:0] w_ch_k;
    logic       w_is_ch;
    logic       w_is_ram;
    logic       w_is_rom;
    logic       w_is_unmapped;
    logic       w_overlay;
    logic       w_start;
    logic [15:0] w_ch_rdata;

    // Channel windows count down from 0x4FFFF0, so the channel number
    // is the inverted window index inside the top 4 KiB page.
    assign w_in_top      = address[22:12] == 11'h4FF;
    assign w_ch_k        = ~address[11:4];
    assign w_is_ch       = w_in_top && (w_ch_k < 8'(NUM_CH));
    assign w_is_ram      = ~address[22];
    assign w_is_rom      = (address[22:20] == 3'b100)
                         && (address[22:10] != 13'h13FF);
    assign w_is_unmapped = address[22] && (address[21:20] != 2'b00);
    assign w_overlay     = r_boot_cnt < BOOT_MAX;
    assign w_start       = cs && (uds || lds) && !r_cs_d
                         && (r_state == IDLE);
    assign csrom         = cs && (w_is_rom || w_overlay);

    always_comb begin
        w_ch_rdata = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_ch_k == 8'(k)) begin
                if (address[3:1] == 3'd0) begin
                    w_ch_rdata = {8'h00, display_active[k], 1'b0,
                                  parity[k], 5'b00000};
                end else begin
                    for (int r = 1; r < REGS_PER_CH; r++) begin
                        if (address[3:1] == 3'(r))
                            w_ch_rdata = r_regs[k][r];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_boot_cnt  <= '0;
            r_cs_d      <= 1'b0;
            r_abort     <= 1'b0;
            r_dout      <= '0;
            r_bus_ack   <= 1'b0;
            r_ram_req   <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_be    <= '0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            for (int k = 0; k < NUM_CH; k++)
                for (int r = 0; r < REGS_PER_CH; r++)
                    r_regs[k][r] <= '0;
        end else begin
            r_cs_d <= cs;
            unique case (r_state)
                IDLE: begin
                    if (w_start) begin
                        if (r_boot_cnt != BOOT_MAX)
                            r_boot_cnt <= r_boot_cnt + BCW'(1);
                        // Overlaid, ROM and sys-I/O cycles belong to
                        // the external device: nothing to do here.
                        if (w_overlay) begin
                            r_state <= IDLE;
                        end else if (w_is_ram) begin
                            r_state     <= RAM_WAIT;
                            r_abort     <= 1'b0;
                            r_ram_req   <= 1'b1;
                            r_ram_we    <= write_strobe;
                            r_ram_be    <= {uds, lds};
                            r_ram_addr  <= address[RAM_AW:1];
                            r_ram_wdata <= din;
                        end else if (w_is_ch) begin
                            r_state   <= ACK;
                            r_bus_ack <= 1'b1;
                            if (write_strobe) begin
                                for (int k = 0; k < NUM_CH; k++)
                                    for (int r = 1; r < REGS_PER_CH; r++)
                                        if (w_ch_k == 8'(k) &&
                                            address[3:1] == 3'(r)) begin
                                            if (uds)
                                                r_regs[k][r][15:8] <= din[15:8];
                                            if (lds)
                                                r_regs[k][r][7:0] <= din[7:0];
                                        end
                            end else begin
                                r_dout <= w_ch_rdata;
                            end
                        end else if (w_is_unmapped) begin
                            r_state   <= ACK;
                            r_bus_ack <= 1'b1;
                            if (!write_strobe)
                                r_dout <= '0;
                        end
                    end
                end
                RAM_WAIT: begin
                    if (!cs)
                        r_abort <= 1'b1;
                    if (ram_ack) begin
                        r_ram_req <= 1'b0;
                        // An aborted cycle still lets the RAM finish,
                        // but the CPU is no longer waiting for it.
                        if (r_abort || !cs) begin
                            r_state <= IDLE;
                        end else begin
                            r_state   <= ACK;
                            r_bus_ack <= 1'b1;
                            if (!r_ram_we)
                                r_dout <= ram_rdata;
                        end
                    end
                end
                ACK: begin
                    r_bus_ack <= 1'b0;
                    r_state   <= RELEASE;
                end
                RELEASE: begin
                    if (!cs)
                        r_state <= IDLE;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        for (genvar r = 0; r < REGS_PER_CH; r++) begin : g_reg
            assign ch_regs[(k*REGS_PER_CH+r)*16 +: 16] = r_regs[k][r];
        end
    end

    assign dout      = r_dout;
    assign bus_ack   = r_bus_ack;
    assign ram_req   = r_ram_req;
    assign ram_we    = r_ram_we;
    assign ram_be    = r_ram_be;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;

endmodule

// File: tb/tb_mcd_bus_ctrl.sv
// tb_mcd_bus_ctrl: directed bench for mcd_bus_ctrl.
// Expected bus_ack responses are queued by the stimulus; a monitor pops them.
module tb_mcd_bus_ctrl;

    localparam int RAM_AW = 21;
    localparam int NUM_CH = 2;
    localparam int REGS   = 8;

    logic                         clk = 1'b0;
    logic                         reset_n = 1'b0;
    logic [22:1]                  address = '0;
    logic [15:0]                  din = '0;
    logic [15:0]                  dout;
    logic                         uds = 1'b0;
    logic                         lds = 1'b0;
    logic                         write_strobe = 1'b0;
    logic                         cs = 1'b0;
    logic                         bus_ack;
    logic                         csrom;
    logic                         ram_req;
    logic                         ram_we;
    logic [1:0]                   ram_be;
    logic [RAM_AW-1:0]            ram_addr;
    logic [15:0]                  ram_wdata;
    logic [15:0]                  ram_rdata = '0;
    logic                         ram_ack = 1'b0;
    logic [NUM_CH-1:0]            display_active = '0;
    logic [NUM_CH-1:0]            parity = '0;
    logic [NUM_CH*REGS*16-1:0]    ch_regs;

    mcd_bus_ctrl #(
        .RAM_AW(RAM_AW), .BOOT_ACCESSES(4),
        .NUM_CH(NUM_CH), .REGS_PER_CH(REGS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .din(din),
        .dout(dout), .uds(uds), .lds(lds), .write_strobe(write_strobe),
        .cs(cs), .bus_ack(bus_ack), .csrom(csrom), .ram_req(ram_req),
        .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack),
        .display_active(display_active), .parity(parity),
        .ch_regs(ch_regs)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        chk;
        logic [15:0] val;
        logic [7:0]  tag;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    logic prev_ack = 1'b0;
    exp_t e;

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus_ack) begin
                total++;
                if (prev_ack) begin
                    bad++;
                    $display("FAIL ack_width: bus_ack high 2 cycles, required 1");
                end else if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_ack: bus_ack=1 required 0");
                end else begin
                    e = q.pop_front();
                    if (e.chk && dout !== e.val) begin
                        bad++;
                        $display("FAIL dout_%0d: got %h required %h",
                                 e.tag, dout, e.val);
                    end
                end
            end
            prev_ack = bus_ack;
        end else begin
            prev_ack = 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [23:0] a, input logic we,
                         input logic u, input logic l,
                         input logic [15:0] d);
        address      = a[22:1];
        write_strobe = we;
        uds          = u;
        lds          = l;
        din          = d;
        cs           = 1'b1;
    endtask

    task automatic finish_cycle();
        cs           = 1'b0;
        uds          = 1'b0;
        lds          = 1'b0;
        write_strobe = 1'b0;
        step();
        step();
    endtask

    task automatic wait_ack(input string nm, input int exp_lat);
        int n = 0;
        while (!bus_ack && n < 20) begin
            step();
            n++;
        end
        if (!bus_ack) begin
            total++;
            bad++;
            $display("FAIL %s: bus_ack timeout got 0 required 1", nm);
        end else if (exp_lat >= 0) begin
            chk(nm, n, exp_lat);
        end
    endtask

    task automatic reg_acc(input logic [23:0] a, input logic we,
                           input logic u, input logic l,
                           input logic [15:0] d, input logic c,
                           input logic [15:0] ev, input logic [7:0] tag);
        q.push_back(exp_t'{c, ev, tag});
        start(a, we, u, l, d);
        wait_ack($sformatf("reg_lat_%0d", tag), 1);
        finish_cycle();
    endtask

    task automatic ram_read(input logic [23:0] a, input logic [15:0] rd,
                            input int dly, input logic [7:0] tag);
        q.push_back(exp_t'{1'b1, rd, tag});
        start(a, 1'b0, 1'b1, 1'b1, 16'h0);
        #1;
        chk("ram_csrom", csrom, 0);
        step();
        chk("ram_req_set", ram_req, 1);
        chk("ram_addr", ram_addr, a[21:1]);
        chk("ram_we_rd", ram_we, 0);
        chk("ram_be_rd", ram_be, 2'b11);
        repeat (dly - 1) step();
        ram_ack   = 1'b1;
        ram_rdata = rd;
        step();
        ram_ack   = 1'b0;
        ram_rdata = 16'h0;
        chk("ram_bus_ack", bus_ack, 1);
        chk("ram_req_clr", ram_req, 0);
        repeat (3) begin
            step();
            chk("ram_no_rereq", ram_req, 0);
        end
        finish_cycle();
    endtask

    task automatic overlay_start(input logic [23:0] a);
        start(a, 1'b0, 1'b1, 1'b1, 16'h0);
        #1;
        chk("ovl_csrom", csrom, 1);
        repeat (3) step();
        chk("ovl_no_req", ram_req, 0);
        cs = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time exceeded");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) step();
        reset_n = 1'b1;
        step();
        chk("rst_dout", dout, 0);
        chk("rst_ack", bus_ack, 0);
        chk("rst_req", ram_req, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_be", ram_be, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_wdata", ram_wdata, 0);
        chk("rst_regs", ch_regs == '0, 1);
        chk("rst_csrom", csrom, 0);

        repeat (4) overlay_start(24'h000000);
        ram_read(24'h000000, 16'h1111, 1, 8'd1);
        ram_read(24'h001234, 16'hBEEF, 3, 8'd2);

        reg_acc(24'h4FFFE2, 1, 1, 0, 16'hAB12, 0, 16'h0, 8'd3);
        chk("byte_wr_uds", ch_regs[(1*REGS+1)*16 +: 16], 16'hAB00);
        reg_acc(24'h4FFFE2, 0, 1, 1, 16'h0, 1, 16'hAB00, 8'd4);
        reg_acc(24'h4FFFE2, 1, 0, 1, 16'h99CD, 0, 16'h0, 8'd5);
        chk("byte_wr_lds", ch_regs[(1*REGS+1)*16 +: 16], 16'hABCD);
        reg_acc(24'h4FFFFE, 1, 1, 1, 16'h1357, 0, 16'h0, 8'd6);
        chk("ch0_r7", ch_regs[7*16 +: 16], 16'h1357);
        reg_acc(24'h4FFFFE, 0, 1, 1, 16'h0, 1, 16'h1357, 8'd7);

        display_active = 2'b01;
        parity         = 2'b01;
        reg_acc(24'h4FFFF0, 0, 1, 1, 16'h0, 1, 16'h00A0, 8'd8);
        reg_acc(24'h4FFFF0, 1, 1, 1, 16'hFFFF, 0, 16'h0, 8'd9);
        reg_acc(24'h4FFFF0, 0, 1, 1, 16'h0, 1, 16'h00A0, 8'd10);
        reg_acc(24'h4FFFE0, 0, 1, 1, 16'h0, 1, 16'h0000, 8'd11);
        display_active = 2'b10;
        parity         = 2'b00;
        reg_acc(24'h4FFFE0, 0, 1, 1, 16'h0, 1, 16'h0080, 8'd12);
        chk("ch0_r0_store", ch_regs[15:0], 16'h0000);

        start(24'h4FFC00, 1'b0, 1'b1, 1'b1, 16'h0);
        #1;
        chk("sysio_csrom", csrom, 0);
        repeat (3) step();
        chk("sysio_no_req", ram_req, 0);
        finish_cycle();

        ram_ack = 1'b1;
        step();
        ram_ack = 1'b0;
        step();

        start(24'h000100, 1'b0, 1'b1, 1'b1, 16'h0);
        step();
        chk("abort_req", ram_req, 1);
        cs = 1'b0;
        step();
        step();
        ram_ack   = 1'b1;
        ram_rdata = 16'h7777;
        step();
        ram_ack = 1'b0;
        chk("abort_req_clr", ram_req, 0);
        finish_cycle();
        reg_acc(24'h4FFFE2, 0, 1, 1, 16'h0, 1, 16'hABCD, 8'd13);

        reg_acc(24'h600000, 0, 1, 1, 16'h0, 1, 16'h0000, 8'd14);
        reg_acc(24'h500000, 1, 1, 1, 16'hFFFF, 0, 16'h0, 8'd15);

        start(24'h000200, 1'b1, 1'b1, 1'b1, 16'h5555);
        step();
        chk("wr_req", ram_req, 1);
        chk("wr_we", ram_we, 1);
        chk("wr_wdata", ram_wdata, 16'h5555);
        chk("wr_be", ram_be, 2'b11);
        chk("wr_addr", ram_addr, 21'h000100);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_req", ram_req, 0);
        chk("arst_regs", ch_regs == '0, 1);
        chk("arst_dout", dout, 0);
        cs = 1'b0;
        step();
        reset_n = 1'b1;
        step();

        repeat (4) overlay_start(24'h001234);
        ram_read(24'h000002, 16'h2468, 2, 8'd16);

        repeat (4) step();
        chk("sb_drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
